// File: rtl/retire_commit.sv
// In-order retirement for the head WAYS slots of the ROB: architectural map and free-list
// updates, mispredict recovery, a committed-store buffer and halt sequencing.
module retire_commit #(
  parameter int unsigned WAYS     = 3,
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AR_BITS  = 5,
  parameter int unsigned PR_BITS  = 6
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WAYS-1:0]             rob_complete,
  input  logic [WAYS-1:0]             rob_has_dest,
  input  logic [WAYS-1:0]             rob_is_store,
  input  logic [WAYS-1:0]             rob_is_halt,
  input  logic [WAYS-1:0]             rob_mispred,
  input  logic [WAYS*AR_BITS-1:0]     rob_ar,
  input  logic [WAYS*PR_BITS-1:0]     rob_t,
  input  logic [WAYS*PR_BITS-1:0]     rob_told,
  input  logic [WAYS*XLEN-1:0]        rob_addr,
  input  logic [WAYS*XLEN-1:0]        rob_data,
  input  logic [WAYS*XLEN-1:0]        rob_target_pc,
  output logic [WAYS-1:0]             retire_en,
  output logic [WAYS-1:0]             arch_wr_en,
  output logic [WAYS*AR_BITS-1:0]     arch_ar,
  output logic [WAYS*PR_BITS-1:0]     arch_pr,
  output logic [WAYS-1:0]             free_en,
  output logic [WAYS*PR_BITS-1:0]     free_pr,
  output logic                        recover_en,
  output logic [XLEN-1:0]             recover_pc,
  output logic                        mem_valid,
  output logic [XLEN-1:0]             mem_addr,
  output logic [XLEN-1:0]             mem_data,
  input  logic                        mem_ready,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        halted
);

  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = CW + 3;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t            state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [XLEN-1:0]   sb_addr [SB_DEPTH];
  logic [XLEN-1:0]   sb_data [SB_DEPTH];

  logic              blocked;
  logic [EW-1:0]     enq_cnt;
  logic [PW-1:0]     slot_off [WAYS];
  logic              halt_ret;
  logic              rec_hit;
  logic [XLEN-1:0]   rec_pc;
  logic              deq;
  logic [CW-1:0]     count_next;

  // Retire scan: the first slot that cannot retire, or that redirects/halts, ends the group.
  always_comb begin
    retire_en  = '0;
    arch_wr_en = '0;
    arch_ar    = '0;
    arch_pr    = '0;
    free_en    = '0;
    free_pr    = '0;
    enq_cnt    = '0;
    halt_ret   = 1'b0;
    rec_hit    = 1'b0;
    rec_pc     = '0;
    blocked    = reset || (state != RUN);
    for (int i = 0; i < WAYS; i++) begin
      slot_off[i] = PW'(enq_cnt);
      if (!blocked && rob_complete[i] &&
          !(rob_is_store[i] && (EW'(sb_count) + enq_cnt >= EW'(SB_DEPTH)))) begin
        retire_en[i]  = 1'b1;
        arch_wr_en[i] = rob_has_dest[i] && (rob_ar[i*AR_BITS +: AR_BITS] != '0);
        free_en[i]    = rob_has_dest[i];
        if (rob_is_store[i]) enq_cnt = enq_cnt + EW'(1);
        if (rob_is_halt[i]) begin
          halt_ret = 1'b1;
          blocked  = 1'b1;
        end else if (rob_mispred[i]) begin
          rec_hit  = 1'b1;
          rec_pc   = rob_target_pc[i*XLEN +: XLEN];
          blocked  = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
    if (!reset) begin
      arch_ar = rob_ar;
      arch_pr = rob_t;
      free_pr = rob_told;
    end
  end

  assign mem_valid  = (sb_count != '0);
  assign mem_addr   = sb_addr[rd_ptr];
  assign mem_data   = sb_data[rd_ptr];
  assign deq        = mem_valid && mem_ready;
  assign count_next = sb_count + CW'(enq_cnt) - CW'(deq);

  // Store buffer payload; retiring stores land at consecutive slots from wr_ptr.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WAYS; i++) begin
      if (retire_en[i] && rob_is_store[i]) begin
        sb_addr[wr_ptr + slot_off[i]] <= rob_addr[i*XLEN +: XLEN];
        sb_data[wr_ptr + slot_off[i]] <= rob_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sb_count   <= '0;
      recover_en <= 1'b0;
      recover_pc <= '0;
      halted     <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(enq_cnt);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      sb_count   <= count_next;
      recover_en <= rec_hit;
      if (rec_hit) recover_pc <= rec_pc;
      case (state)
        RUN: begin
          if (halt_ret) begin
            if (count_next != '0) begin
              state <= DRAIN;
            end else begin
              state  <= HALTED;
              halted <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (sb_count == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule
